// File: rtl/spi_slave_regs.sv
// SPI mode-0 slave with a bank of 8-bit registers, read and written with 16-bit frames.
// Every SPI input is resynchronised into clk, and the whole block runs in the clk domain.
module spi_slave_regs #(
    parameter int NUM_REGS    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    output logic       wr_strobe,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_e;

    localparam int        AW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [7:0] NREGS = 8'(NUM_REGS);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   scl_d;
    logic                   cs_d;
    logic                   primed;
    logic                   armed;

    logic       scl_s, cs_s, mosi_s;
    logic       scl_rise, scl_fall, cs_fall, cs_rise;

    state_e     state;
    logic [4:0] bit_cnt;
    logic [6:0] shift_in;
    logic       rw;
    logic [6:0] addr;
    logic [6:0] shift_out;
    logic       miso_r;
    logic [7:0] regs [NUM_REGS];

    logic [7:0] rx_byte;
    logic [7:0] rd_word;
    logic       addr_ok;
    logic       rd_ok;

    // Synchronizers and edge-detect history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            scl_d     <= 1'b0;
            cs_d      <= 1'b1;
            primed    <= 1'b0;
            armed     <= 1'b0;
        end else begin
            scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            scl_d     <= scl_s;
            cs_d      <= cs_s;
            primed    <= 1'b1;
            // A frame may start only after cs_n has been seen high since reset,
            // so a select held low across reset release is not taken as a new frame.
            armed     <= armed | (primed & cs_sync[0]);
        end
    end

    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign cs_fall  = cs_d & ~cs_s & armed;
    assign cs_rise  = ~cs_d & cs_s;

    assign rx_byte  = {shift_in, mosi_s};
    assign addr_ok  = ({1'b0, addr} < NREGS);
    assign rd_ok    = ({1'b0, rd_addr} < NREGS);
    assign rd_word  = addr_ok ? regs[addr[AW-1:0]] : 8'h00;

    // Frame FSM, register bank and serial output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= 5'd0;
            shift_in  <= 7'd0;
            rw        <= 1'b0;
            addr      <= 7'd0;
            shift_out <= 7'd0;
            miso_r    <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= 7'd0;
            wr_data   <= 8'd0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 8'd0;
            end
        end else begin
            wr_strobe <= 1'b0;
            if (cs_rise) begin
                state  <= IDLE;
                miso_r <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            state    <= CMD;
                            bit_cnt  <= 5'd0;
                            shift_in <= 7'd0;
                            miso_r   <= 1'b0;
                        end
                    end
                    CMD: begin
                        if (scl_rise) begin
                            shift_in <= {shift_in[5:0], mosi_s};
                            bit_cnt  <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                rw    <= shift_in[6];
                                addr  <= {shift_in[5:0], mosi_s};
                                state <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (scl_rise) begin
                            shift_in <= {shift_in[5:0], mosi_s};
                            bit_cnt  <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd15) begin
                                state <= DONE;
                                if (!rw && addr_ok) begin
                                    regs[addr[AW-1:0]] <= rx_byte;
                                    wr_strobe          <= 1'b1;
                                    wr_addr            <= addr;
                                    wr_data            <= rx_byte;
                                end
                            end
                        end else if (scl_fall && rw) begin
                            // The first falling edge of the data phase loads the register
                            // and presents its MSB; later ones shift the remaining bits out.
                            if (bit_cnt == 5'd8) begin
                                shift_out <= rd_word[6:0];
                                miso_r    <= rd_word[7];
                            end else begin
                                miso_r    <= shift_out[6];
                                shift_out <= {shift_out[5:0], 1'b0};
                            end
                        end
                    end
                    DONE: begin
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= 8'd0;
        end else begin
            rd_data <= rd_ok ? regs[rd_addr[AW-1:0]] : 8'h00;
        end
    end

    assign miso_oe = ~cs_s;
    assign miso    = miso_r & miso_oe;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Bench for spi_slave_regs: an SPI master drives directed and random frames, a register-array model
// predicts the results, and a strobe monitor checks each committed write against a queue of expected writes.
module tb_spi_slave_regs;

    localparam int NUM_REGS = 16;
    localparam int HALF     = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic       miso_oe;
    logic       wr_strobe;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic [6:0] rd_addr = 7'd0;
    logic [7:0] rd_data;

    int checks = 0;
    int errors = 0;

    logic [7:0]  model [128];
    logic [14:0] exp_q [$];
    logic [14:0] wr_e;

    spi_slave_regs #(.NUM_REGS(NUM_REGS), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .scl(scl), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .wr_strobe(wr_strobe),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write
    always @(negedge clk) begin
        if (rst_n && wr_strobe) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 32'(wr_strobe), 32'd0);
            end else begin
                wr_e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(wr_e[14:8]));
                check("wr_data", 32'(wr_data), 32'(wr_e[7:0]));
            end
        end
    end

    task automatic reset_pulse();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_miso_oe", 32'(miso_oe), 32'd0);
        check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        for (int i = 0; i < 128; i++) model[i] = 8'd0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Drive one frame of nbits MSB-first; optionally pulse reset before bit rst_at
    task automatic spi_frame(input logic [31:0] bits, input int nbits, input int rst_at,
                             output logic [7:0] rx);
        rx = 8'd0;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) reset_pulse();
            mosi = bits[nbits-1-i];
            repeat (HALF) @(negedge clk);
            if (i == 4 && rst_at < 0) begin
                check("miso_oe_active", 32'(miso_oe), 32'd1);
                check("miso_cmd_zero", 32'(miso), 32'd0);
            end
            if (i >= 8 && i < 16) rx = {rx[6:0], miso};
            scl = 1'b1;
            repeat (HALF) @(negedge clk);
            scl = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (8) @(negedge clk);
        check("miso_oe_idle", 32'(miso_oe), 32'd0);
        check("miso_idle", 32'(miso), 32'd0);
    endtask

    // Reference: a frame of >=16 bits acts on its first 16; writes hit only implemented registers
    task automatic issue(input logic [31:0] bits, input int nbits);
        logic [15:0] f;
        logic [7:0]  rx;
        logic [7:0]  exp;
        bit          is_rd;
        is_rd = 1'b0;
        exp   = 8'd0;
        if (nbits >= 16) begin
            f = 16'(bits >> (nbits - 16));
            if (f[15]) begin
                is_rd = 1'b1;
                exp   = (int'(f[14:8]) < NUM_REGS) ? model[f[14:8]] : 8'd0;
            end else if (int'(f[14:8]) < NUM_REGS) begin
                model[f[14:8]] = f[7:0];
                exp_q.push_back({f[14:8], f[7:0]});
            end
        end
        spi_frame(bits, nbits, -1, rx);
        if (is_rd) check("miso_read", 32'(rx), 32'(exp));
        check("strobe_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic rd_check(input logic [6:0] a);
        rd_addr = a;
        repeat (2) @(negedge clk);
        check("rd_data", 32'(rd_data), (int'(a) < NUM_REGS) ? 32'(model[a]) : 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  rx;
        logic [15:0] f16;
        logic [31:0] bits;
        int          nbits;
        int          r;

        for (int i = 0; i < 128; i++) model[i] = 8'd0;
        reset_pulse();
        rd_check(7'd3);

        issue(32'h03A5, 16);
        rd_check(7'd3);
        issue(32'h8300, 16);

        issue(32'h4012, 16);
        issue(32'hC000, 16);
        rd_check(7'h40);

        issue(32'h05F, 12);
        rd_check(7'd5);
        issue(32'h0533, 16);
        rd_check(7'd5);

        issue(32'h077755, 24);
        rd_check(7'd7);
        issue(32'h8700, 16);

        // Reset during bit 10 of a write; select stays low after release
        spi_frame(32'h0A5A, 16, 10, rx);
        check("strobe_after_reset", 32'(exp_q.size()), 32'd0);
        rd_check(7'd3);
        rd_check(7'd10);
        issue(32'h0A5A, 16);
        rd_check(7'd10);

        for (int n = 0; n < 30; n++) begin
            r     = $urandom_range(0, 9);
            nbits = (r < 7) ? 16 : ((r < 8) ? 12 : 20);
            f16   = {($urandom_range(0, 2) == 0), 7'($urandom_range(0, 19)), 8'($urandom)};
            if (nbits == 16)      bits = {16'd0, f16};
            else if (nbits == 12) bits = {20'd0, f16[15:4]};
            else                  bits = {12'd0, f16, 4'($urandom)};
            issue(bits, nbits);
            rd_check(7'($urandom_range(0, 19)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
